// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage: opcodes, ALU operand
// select codes, the decoded control bundle and the stage state encoding.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALU_SRC_REG = 2'd0;
  localparam logic [1:0] ALU_SRC_IMM = 2'd1;
  localparam logic [1:0] ALU_SRC_PC  = 2'd2;
  localparam logic [1:0] ALU_SRC_NPC = 2'd3;

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic [2:0] memsize;
    logic       branch;
    logic [1:0] alusrc;
    logic       alusrc_a_zero;
    logic       regwrite;
    logic       jump;
    logic       jumpsrc;
    logic       hlt;
    logic       illegal;
    logic       muldiv;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side valid/ready bundle of the decode stage.
// The stage uses the slave modport; fetch/execute models use master.
interface decode_stage_if #(
  parameter int XLEN = 32
) ();

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [XLEN-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  decode_pkg::ctrl_t  out_ctrl;
  logic [31:0]        out_instr;
  logic [XLEN-1:0]    out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_instr, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_instr, out_pc
  );

endinterface

// File: rtl/decode_stage_ctrl_decode.sv
// Combinational RV32I opcode decoder with legality check.
// DECODE_MEXT_EN makes OP with funct7=0000001 legal and raises muldiv.
module ctrl_decode
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl = '0;
    case (opcode)
      OPC_AUIPC: begin
        ctrl.alusrc        = ALU_SRC_PC;
        ctrl.alusrc_a_zero = 1'b1;
        ctrl.regwrite      = 1'b1;
      end
      OPC_LUI: begin
        ctrl.alusrc        = ALU_SRC_IMM;
        ctrl.alusrc_a_zero = 1'b1;
        ctrl.regwrite      = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alusrc   = ALU_SRC_IMM;
        ctrl.regwrite = 1'b1;
      end
      OPC_OP: begin
        if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          ctrl.alusrc   = ALU_SRC_REG;
          ctrl.regwrite = 1'b1;
        end
`ifdef DECODE_MEXT_EN
        else if (funct7 == F7_MULDIV) begin
          ctrl.alusrc   = ALU_SRC_REG;
          ctrl.regwrite = 1'b1;
          ctrl.muldiv   = 1'b1;
        end
`endif
        else begin
          ctrl.illegal = 1'b1;
          ctrl.hlt     = 1'b1;
        end
      end
      OPC_BRANCH: begin
        ctrl.alusrc = ALU_SRC_REG;
        ctrl.branch = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        ctrl.alusrc        = ALU_SRC_NPC;
        ctrl.alusrc_a_zero = 1'b1;
        ctrl.jump          = 1'b1;
        ctrl.regwrite      = 1'b1;
        ctrl.jumpsrc       = (opcode == OPC_JALR);
      end
      OPC_LOAD: begin
        ctrl.alusrc   = ALU_SRC_IMM;
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.memsize  = funct3;
      end
      OPC_STORE: begin
        ctrl.alusrc   = ALU_SRC_IMM;
        ctrl.memwrite = 1'b1;
        ctrl.memsize  = funct3;
      end
      OPC_SYSTEM: begin
        ctrl.hlt = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
        ctrl.hlt     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder, output FIFO toward execute, drain/halt FSM.
// Optional M-extension decode is enabled with DECODE_MEXT_EN (see ctrl_decode).
//
// state  | meaning
// RUN    | accepting instructions while the FIFO has room
// DRAIN  | halting instruction accepted; deliver buffered entries, accept none
// HALTED | FIFO drained after a halt; sticky until reset
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  decode_stage_if.slave  bus,
  output logic           halted,
  output logic           illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t           state;
  ctrl_t            dec_ctrl;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  ctrl_t            mem_ctrl  [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [XLEN-1:0]  mem_pc    [DEPTH];

  ctrl_decode u_ctrl_decode (
    .instr (bus.in_instr),
    .ctrl  (dec_ctrl)
  );

  // Reset gates in_ready so fetch never sees a handshake while reset is held.
  assign bus.in_ready  = !reset && (state == RUN) && !flush && (count < CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_ctrl  = mem_ctrl[rd_ptr];
  assign bus.out_instr = mem_instr[rd_ptr];
  assign bus.out_pc    = mem_pc[rd_ptr];

  assign push      = bus.in_valid && bus.in_ready;
  assign pop       = bus.out_valid && bus.out_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      halted  <= 1'b0;
      illegal <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ctrl[i]  <= '0;
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else begin
      if (flush && state != HALTED) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem_ctrl[wr_ptr]  <= dec_ctrl;
          mem_instr[wr_ptr] <= bus.in_instr;
          mem_pc[wr_ptr]    <= bus.in_pc;
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count_nxt;
      end

      case (state)
        RUN: begin
          if (push && dec_ctrl.hlt) begin
            state   <= DRAIN;
            illegal <= dec_ctrl.illegal;
          end
        end
        DRAIN: begin
          // The halting instruction was speculative if a flush arrives first.
          if (flush) begin
            state   <= RUN;
            illegal <= 1'b0;
          end else if (count_nxt == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
  a_no_push_drain: assert property (@(posedge clk) disable iff (reset) state != RUN |-> !push);

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage for the RV32I core. Takes fetched instruction/PC pairs over a valid/ready handshake, decodes them into a control bundle, and buffers the results in a small FIFO toward execute. Illegal and SYSTEM opcodes produce a controlled drain-then-halt sequence with a sticky status instead of terminating simulation. Supports a pipeline flush.

## Interface
- XLEN, 32: PC width.
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  squash all buffered and incoming instructions.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  execute consumes head.
- out_ctrl  out  ctrl_t  decoded control bundle of head.
- out_instr  out  32  head instruction word.
- out_pc  out  XLEN  head PC.
- halted  out  1  sticky; core stopped.
- illegal  out  1  halt cause was an illegal instruction.

## Operation
- ctrl_t fields: memtoreg, memwrite, memsize[2:0], branch, alusrc[1:0] (REG/IMM/PC/NPC), alusrc_a_zero, regwrite, jump, jumpsrc (0 = PC base, 1 = rs1 base), hlt, illegal, muldiv.
- Decode per opcode: AUIPC → alusrc=PC, a_zero, regwrite. LUI → IMM, a_zero, regwrite. OP-IMM → IMM, regwrite. OP → REG, regwrite. BRANCH → REG, branch. JAL/JALR → NPC, a_zero, jump, regwrite, jumpsrc=(JALR). LOAD → IMM, regwrite, memtoreg, memsize=funct3. STORE → IMM, memwrite, memsize=funct3. SYSTEM → hlt. Any other opcode, or OP with funct7 not 0000000/0100000 (see Configuration) → illegal=1, hlt=1.
- Unused fields are driven 0; no X values on outputs.
- Accept: in_valid && in_ready. in_ready = (state==RUN) && !flush && count<DEPTH. No push into a full FIFO, even when popping the same cycle.
- Pop: out_valid && out_ready.
- States:
  - RUN: the normal state.
  - DRAIN: entered on accepting an entry with hlt=1; accepts nothing more.
  - HALTED: entered from DRAIN when the FIFO is empty and not flushing; sets halted=1.
- HALTED is sticky until reset. The hlt entry itself is delivered downstream before the halt.
- illegal register: set on accepting an illegal entry; cleared on flush while in DRAIN; held in HALTED.
- flush:
  - Empties the FIFO the same cycle.
  - Drops any input that cycle.
  - DRAIN → RUN, because the halting instruction was speculative.
  - No effect in HALTED.
- flush during reset: reset wins.

## Timing
- Reset values: out_valid=0, in_ready=0, out_ctrl=0, out_instr=0, out_pc=0, halted=0, illegal=0, count=0, state=RUN.
- in_ready may rise the first cycle after reset deasserts.
- Latency: an entry accepted at cycle N shows out_valid=1 at N+1. Outputs come from FIFO registers.
- Throughput: one instruction per cycle while count<DEPTH and downstream pops every cycle.
- Head fields hold stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH. count range is 0..DEPTH, width clog2(DEPTH)+1.
- A hlt accepted at cycle N: in_ready=0 from N+1.
  - halted=1 the cycle after the last pop empties the FIFO.
  - With an empty FIFO and immediate pop at N+1, halted=1 at N+2.

## Configuration
- DECODE_MEXT_EN defined: OP with funct7=0000001 decodes as the OP case plus muldiv=1, and is legal.
- DECODE_MEXT_EN undefined: that encoding is illegal (illegal=1, hlt=1); muldiv is tied 0.

## Structure
- Package decode_pkg:
  - opcode constants (OPC_*);
  - ALU_SRC_* constants;
  - ctrl_t packed struct;
  - state enum {RUN, DRAIN, HALTED}.
- One combinational sub-module, ctrl_decode: maps instr to ctrl_t, including legality checks.
- The FIFO, state machine and status registers sit in decode_stage.

## Test plan
- Reset, then stream ADDI, LW (funct3=010), SW, JALR with out_ready=1 → one out per cycle at 1-cycle latency; LW gives memsize=010, memtoreg=1; JALR gives jump=1, jumpsrc=1, alusrc=NPC.
- Hold out_ready=0 and push 3 instructions with DEPTH=2 → in_ready drops after 2 accepts; head stable; order preserved after release.
- Opcode 0x7F with 1 older entry buffered → in_ready=0 next cycle; both entries delivered; then halted=1, illegal=1; further in_valid ignored.
- ECALL, then flush while in DRAIN → FIFO empty, state RUN, illegal=0, halted=0; the next ADD is accepted.
- MUL (funct7=0000001) → with DECODE_MEXT_EN: muldiv=1, regwrite=1. Without it: illegal=1, then halt.
- Assert reset mid-stream with a full FIFO → all outputs at reset values the next cycle, and not halted.
